// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32I subset encoder/loader: op codes, opcode/funct
// fields, the canonical NOP word, the loader FSM states and the descriptor struct.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        OP_ADDI = 3'd0,
        OP_BNE  = 3'd1,
        OP_ADD  = 3'd2,
        OP_LBU  = 3'd3,
        OP_SB   = 3'd4,
        OP_JAL  = 3'd5,
        OP_JALR = 3'd6,
        OP_NOP  = 3'd7
    } op_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [6:0] F7_ADD  = 7'b0000000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } desc_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Descriptor handshake plus instruction-memory write port of the loader.
interface instr_encoder_loader_if #(parameter int ADDR_WIDTH = 8);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_op;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [31:0]           in_imm;
    logic                  in_last;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encode_comb.sv
// Combinational RV32I encoder for one descriptor; flags immediates the format cannot hold.
module instr_encode_comb
    import instr_enc_pkg::*;
(
    input  desc_t       desc,
    output logic [31:0] word,
    output logic        range_err
);

    logic [31:0] imm;
    logic        i_ok, b_ok, j_ok;

    assign imm = desc.imm;
    // A value fits an N-bit signed field when all bits above N-1 copy bit N-1.
    assign i_ok = (imm[31:11] == {21{imm[11]}});
    assign b_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    assign j_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];

    always_comb begin
        word      = NOP_WORD;
        range_err = 1'b0;
        case (desc.op)
            OP_ADDI: begin
                word      = {imm[11:0], desc.rs1, F3_ADDI, desc.rd, OPC_OP_IMM};
                range_err = !i_ok;
            end
            OP_BNE: begin
                word      = {imm[12], imm[10:5], desc.rs2, desc.rs1, F3_BNE,
                             imm[4:1], imm[11], OPC_BRANCH};
                range_err = !b_ok;
            end
            OP_ADD:  word = {F7_ADD, desc.rs2, desc.rs1, F3_ADD, desc.rd, OPC_OP};
            OP_LBU: begin
                word      = {imm[11:0], desc.rs1, F3_LBU, desc.rd, OPC_LOAD};
                range_err = !i_ok;
            end
            OP_SB: begin
                word      = {imm[11:5], desc.rs2, desc.rs1, F3_SB, imm[4:0], OPC_STORE};
                range_err = !i_ok;
            end
            OP_JAL: begin
                word      = {imm[20], imm[10:1], imm[11], imm[19:12], desc.rd, OPC_JAL};
                range_err = !j_ok;
            end
            OP_JALR: begin
                word      = {imm[11:0], desc.rs1, F3_JALR, desc.rd, OPC_JALR};
                range_err = !i_ok;
            end
            OP_NOP:  word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Session-based instruction loader: encodes descriptors and writes them to memory.
// Define INSTR_ENC_CHECKSUM_EN to add a running XOR checksum of the words written.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_WIDTH:0] count,
    output logic                done,
    output logic                err,
    output logic                full
`ifdef INSTR_ENC_CHECKSUM_EN
    ,
    output logic [31:0]         checksum
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // With a non-zero base the session stops at the top of memory rather than wrapping.
    localparam int CAP = DEPTH - BASE_ADDR;
    localparam logic [ADDR_WIDTH:0]   CAP_M1 = (ADDR_WIDTH + 1)'(CAP - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);

    state_e                state;
    logic [ADDR_WIDTH-1:0] ptr;
    desc_t                 desc;
    logic [31:0]           word;
    logic                  range_err;
    logic                  accept;
    logic                  at_cap;

    assign desc   = '{op: op_e'(bus.in_op), rd: bus.in_rd, rs1: bus.in_rs1,
                      rs2: bus.in_rs2, imm: bus.in_imm};
    assign accept = (state == S_LOAD) && bus.in_valid && bus.in_ready;
    assign at_cap = (count == CAP_M1);

    instr_encode_comb u_enc (
        .desc      (desc),
        .word      (word),
        .range_err (range_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE;
            bus.mem_wdata <= '0;
            ptr           <= BASE;
            count         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            full          <= 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (accept && range_err) begin
                        state        <= S_ERR;
                        err          <= 1'b1;
                        bus.in_ready <= 1'b0;
                    end else if (accept) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= ptr;
                        bus.mem_wdata <= word;
                        ptr           <= ptr + 1'b1;
                        count         <= count + 1'b1;
`ifdef INSTR_ENC_CHECKSUM_EN
                        checksum      <= checksum ^ word;
`endif
                        if (at_cap) full <= 1'b1;
                        if (at_cap || bus.in_last) begin
                            state        <= S_DONE;
                            done         <= 1'b1;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state        <= S_LOAD;
                        bus.in_ready <= 1'b1;
                        ptr          <= BASE;
                        count        <= '0;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        full         <= 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
                        checksum     <= '0;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encodes a stream of abstract instruction descriptors into RV32I machine words and writes them sequentially into instruction memory through a simple write port. It covers the same subset the control unit decodes: addi, bne, add, lbu, sb, jal, jalr, plus nop. It serves as the bench/boot-time program loader and produces golden encodings for decoder regression.

Parameters:
ADDR_WIDTH, 8, word-address width of instruction memory; capacity DEPTH = 2**ADDR_WIDTH words
BASE_ADDR, 0, first word address written after reset/start

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begin/restart a load session
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid && in_ready
in_op  in  3  0 ADDI, 1 BNE, 2 ADD, 3 LBU, 4 SB, 5 JAL, 6 JALR, 7 NOP
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  signed immediate, byte offset for branches/jumps
in_last  in  1  marks final descriptor of session
mem_we  out  1  one-cycle write strobe
mem_addr  out  ADDR_WIDTH  word address
mem_wdata  out  32  encoded instruction
count  out  ADDR_WIDTH+1  words written this session
done  out  1  session ended normally (last written or memory full)
err  out  1  sticky; immediate out of range
full  out  1  DEPTH words written

Behaviour:
- Clocking: single clock domain clk; synchronous active-high reset rst.
- Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, done=0, err=0, full=0. A write pending at reset is dropped.
- FSM states:
  - IDLE: start -> LOAD, clearing ptr, count, done, err and full.
  - LOAD: in_ready=1. On accept, the word is registered and written the next cycle (mem_we=1, mem_addr=ptr). ptr and count increment with the write. Throughput is 1 word/cycle.
  - DONE: entered on the cycle the write for an accepted in_last lands, or when count reaches DEPTH (full=1). in_ready=0.
  - ERR: entered on accept of a range-violating descriptor. No write for it, err=1, in_ready=0.
  - DONE and ERR return to LOAD (with clear) only on start. start in LOAD is ignored. No address wrap-around.
- in_ready is registered: in_ready is 0 in the cycle after accepting the descriptor that brings count to DEPTH or carries in_last.
- Encoding (opcode/funct3/funct7):
  - ADDI 0010011/000, I-type.
  - ADD 0110011/000/0000000, R-type.
  - LBU 0000011/100, I-type.
  - SB 0100011/000, S-type.
  - BNE 1100011/001, B-type.
  - JAL 1101111, J-type.
  - JALR 1100111/000, I-type.
  - NOP = 0x00000013.
- Unused register fields: encoded as 0.
- Range checks:
  - I/S imm must lie in [-2048, 2047].
  - B imm must lie in [-4096, 4094] and be even.
  - J imm must lie in [-2^20, 2^20-2] and be even.
  - Violation -> ERR.
- Simultaneous in_last and count reaching DEPTH: done=1 and full=1.

Optional Feature:
INSTR_ENC_CHECKSUM_EN:
- When defined: adds output port checksum[31:0], the XOR of every mem_wdata written this session. It is cleared by rst and start and updates in the same cycle as mem_we.
- When undefined: the port and its logic are absent.

Decomposition:
Package instr_enc_pkg:
- op enum values 0..7
- opcode/funct3/funct7 constants (shared with the control unit bench)
- NOP_WORD constant
- FSM state enum

Sub-module instr_encode_comb: purely combinational; op/fields/imm -> word and range_err.

Test Plan:
- start, then ADDI rd=1 rs1=0 imm=5 -> next cycle mem_we=1, addr=0, wdata=0x00500093, count=1.
- Back-to-back, one per cycle:
  - ADD rd3,rs1=1,rs2=2 -> 0x002081B3.
  - LBU rd5,rs1=1,imm3 -> 0x0030C283.
  - SB rs1=1,rs2=2,imm4 -> 0x00208223.
  - Expect consecutive addrs 0..2 and no bubbles.
- Control flow:
  - BNE rs1=1,rs2=0,imm=-8 -> 0xFE009CE3.
  - JAL rd=1,imm=16 -> 0x010000EF.
  - JALR rd0,rs1=1,imm0 with in_last -> 0x00008067, then done=1, in_ready=0.
- Error: ADDI imm=2048 -> no mem_we, err=1, ERR state. start -> err=0, count=0, next write at addr 0. BNE imm=3 (odd) -> err=1.
- Full: ADDR_WIDTH=2, drive 5 NOPs -> 4 writes of 0x00000013 at addrs 0..3, full=1, done=1, fifth descriptor never accepted.
- Reset mid-stream: rst asserted while a write is pending -> mem_we=0 next cycle, all outputs at reset values, state IDLE.
- With INSTR_ENC_CHECKSUM_EN: the three words of the back-to-back scenario -> checksum = 0x002081B3 ^ 0x0030C283 ^ 0x00208223.
